// File: rtl/io_bank_pkg.sv
// Shared constants and elaboration-time parameter check for the registered I/O bank.
package io_bank_pkg;

  localparam int unsigned MAX_SYNC_STAGES = 3;
  localparam int unsigned MAX_CHANNELS    = 32;
  localparam logic        IO_RST_VAL      = 1'b0;

  function automatic bit io_params_ok(input int unsigned n_in,
                                      input int unsigned n_out,
                                      input int unsigned sync_stages,
                                      input int unsigned in_reg,
                                      input int unsigned out_reg,
                                      input int unsigned oe_reg);
    return (n_in >= 1) && (n_in <= MAX_CHANNELS) &&
           (n_out >= 1) && (n_out <= MAX_CHANNELS) &&
           (sync_stages <= MAX_SYNC_STAGES) &&
           (in_reg <= 1) && (out_reg <= 1) && (oe_reg <= 1);
  endfunction

endpackage

// File: rtl/io_in_chan.sv
// One input channel: free-running synchroniser, gated capture register with latch,
// and registered rise/fall detection on the captured value.
module io_in_chan
  import io_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IN_REG      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic in_latch,
  input  logic in_pin,
  output logic in_data,
  output logic in_rise,
  output logic in_fall
);

  logic w_s;
  logic w_load;
  logic r_p;
  logic r_rise;
  logic r_fall;

  if (SYNC_STAGES == 0) begin : g_no_sync
    assign w_s = in_pin;
  end else begin : g_sync
    // Newest sample enters at bit 0; the oldest stage is the synchronised output.
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync <= {SYNC_STAGES{IO_RST_VAL}};
      end else begin
        r_sync <= SYNC_STAGES'({r_sync, in_pin});
      end
    end
    assign w_s = r_sync[SYNC_STAGES-1];
  end

  assign w_load = cen & ~in_latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p    <= IO_RST_VAL;
      r_rise <= IO_RST_VAL;
      r_fall <= IO_RST_VAL;
    end else if (w_load) begin
      r_rise <= w_s & ~r_p;
      r_fall <= ~w_s & r_p;
      r_p    <= w_s;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  if (IN_REG != 0) begin : g_in_reg
    assign in_data = r_p;
  end else begin : g_in_pass
    assign in_data = in_latch ? r_p : w_s;
  end

  assign in_rise = r_rise;
  assign in_fall = r_fall;

endmodule

// File: rtl/io_reg_bank.sv
// Registered pin bank: N_IN synchronised/latched input channels with edge detect,
// and N_OUT output channels with optional data/enable registers and tristate masking.
module io_reg_bank
  import io_bank_pkg::*;
#(
  parameter int unsigned N_IN        = 5,
  parameter int unsigned N_OUT       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IN_REG      = 1,
  parameter int unsigned OUT_REG     = 1,
  parameter int unsigned OE_REG      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             in_latch,
  input  logic [N_IN-1:0]  in_pin,
  output logic [N_IN-1:0]  in_data,
  output logic [N_IN-1:0]  in_rise,
  output logic [N_IN-1:0]  in_fall,
  input  logic [N_OUT-1:0] out_data,
  input  logic [N_OUT-1:0] out_oe,
  output logic [N_OUT-1:0] out_pin,
  output logic [N_OUT-1:0] out_pin_oe
);

  if (!io_params_ok(N_IN, N_OUT, SYNC_STAGES, IN_REG, OUT_REG, OE_REG)) begin : g_param_err
    $error("io_reg_bank: illegal parameter combination");
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    io_in_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .IN_REG     (IN_REG)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .cen     (cen),
      .in_latch(in_latch),
      .in_pin  (in_pin[i]),
      .in_data (in_data[i]),
      .in_rise (in_rise[i]),
      .in_fall (in_fall[i])
    );
  end

  logic [N_OUT-1:0] w_out;
  logic [N_OUT-1:0] w_oe;

  if (OUT_REG != 0) begin : g_out_reg
    logic [N_OUT-1:0] r_out;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_out <= {N_OUT{IO_RST_VAL}};
      end else if (cen) begin
        r_out <= out_data;
      end
    end
    assign w_out = r_out;
  end else begin : g_out_comb
    assign w_out = out_data;
  end

  if (OE_REG != 0) begin : g_oe_reg
    logic [N_OUT-1:0] r_oe;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_oe <= {N_OUT{IO_RST_VAL}};
      end else if (cen) begin
        r_oe <= out_oe;
      end
    end
    assign w_oe = r_oe;
  end else begin : g_oe_comb
    assign w_oe = out_oe;
  end

  // Tristated pins drive a deterministic 0 rather than stale data.
  assign out_pin    = w_out & w_oe;
  assign out_pin_oe = w_oe;

endmodule

// File: doc/io_reg_bank.md
Name: io_reg_bank

Overview:
- Parametrised, registered I/O bank for the ice40 pack/test harness.
- Sits between package pins and a user `top`, the way a row of SB_IO cells would.
- Adds what the single-purpose IO cells in the harness lack: configurable channel counts, an input synchroniser, clock-enable-gated registered inputs and outputs, input latching, and per-channel edge detection.
- Gives `top` designs a deterministic, cycle-accurate pin model for simulation and packing tests.

Parameters:
- N_IN, 5, number of input channels (1..32)
- N_OUT, 4, number of output channels (1..32)
- SYNC_STAGES, 2, input synchroniser depth (0..3); 0 = no synchroniser
- IN_REG, 1, 1 = input capture register present; 0 = pass-through of the synchroniser output
- OUT_REG, 1, 1 = out_pin registered; 0 = combinational
- OE_REG, 1, 1 = out_pin_oe registered; 0 = combinational

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable for capture and output registers (mirrors SB_IO CLOCK_ENABLE)
- in_latch  in  1  LATCH_INPUT_VALUE: freeze in_data while high
- in_pin  in  N_IN  package-side inputs
- in_data  out  N_IN  captured input values to core
- in_rise  out  N_IN  one-cycle pulse, captured 0->1
- in_fall  out  N_IN  one-cycle pulse, captured 1->0
- out_data  in  N_OUT  core output values
- out_oe  in  N_OUT  core output enables
- out_pin  out  N_OUT  package-side outputs; forced 0 while out_pin_oe=0
- out_pin_oe  out  N_OUT  package-side enables (0 = tristate)

Behaviour:
- Reset: all registers (sync chain, capture p, edge, out, oe) go to 0 on the clk edge where rst=1. rst overrides cen and in_latch.
  - Outputs after reset: in_data=0, in_rise=0, in_fall=0, out_pin=0, out_pin_oe=0.
  - Reset mid-operation discards all in-flight sync data. Edge pulses must not fire on the first capture after reset if the pin is 0.
- Sync chain:
  - SYNC_STAGES flops per input, free-running: not gated by cen or in_latch.
  - s = last stage output; s = in_pin when SYNC_STAGES=0.
- Capture register p[i]: loads s[i] on an edge with cen=1 and in_latch=0; otherwise holds.
- in_data:
  - IN_REG=1: in_data = p.
  - IN_REG=0: in_data = in_latch ? p : s.
- Edges:
  - in_rise[i] is registered: set to s[i] & ~p[i] on a load edge; 0 on any non-load edge (cen=0 or in_latch=1).
  - in_fall is symmetric.
  - Each pulse lasts exactly 1 cycle per capture transition; it never repeats while the value is stable.
- Latency, pin change to in_data:
  - SYNC_STAGES + IN_REG cycles with cen=1.
  - Edge pulse is concurrent with in_data update when IN_REG=1.
- Latch:
  - Asserting in_latch freezes p and in_data from the next edge.
  - Deasserting resumes loading at the next edge with cen=1. Any difference accumulated while latched produces a single rise/fall pulse.
- Outputs:
  - OUT_REG=1: out_pin register loads out_data when cen=1, else holds.
  - OE_REG=1: OE register loads out_oe when cen=1, else holds.
  - Unregistered variants are combinational.
  - The final out_pin is the data value ANDed with the final OE (deterministic 0 when tristated).
  - Latency out_data to out_pin is OUT_REG cycles.
- Simultaneous events:
  - rst + cen: reset wins.
  - cen + in_latch: latch wins for the input path; outputs still load.
- Illegal parameters (N_IN/N_OUT outside 1..32, SYNC_STAGES>3, REG flags not 0/1): elaboration-time error.

Decomposition:
- Package io_bank_pkg:
  - MAX_SYNC_STAGES=3, MAX_CHANNELS=32, reset constant IO_RST_VAL=1'b0
  - Parameter-check function used by the elaboration error
- Sub-module io_in_chan: one input channel (sync chain, capture register, latch, edge detect). Instantiated N_IN times via generate.
- Output path is simple enough to stay inline.

Test Plan:
- Reset: drive in_pin=5'b11111, out_oe=4'hF, rst=1 for 3 cycles -> in_data=0, in_rise=0, out_pin=0, out_pin_oe=0; first capture after release gives in_rise=5'b11111 for exactly 1 cycle.
- Latency: defaults, cen=1, in_pin[2] 0->1 at cycle 0 -> in_data[2]=1 and in_rise[2]=1 at cycle 3; in_rise[2]=0 at cycle 4.
- cen gating: cen=0, out_data=4'hA, out_oe=4'hF -> out_pin holds 0. Raise cen -> out_pin=4'hA and out_pin_oe=4'hF one cycle later.
- Latch: in_latch=1, toggle in_pin[0] 1->0->1->0 over 6 cycles -> in_data[0] and edges unchanged. Release -> single in_fall[0] pulse 1 cycle later.
- Tristate masking: out_data=4'hF, out_oe=4'b0101 -> out_pin=4'b0101 after 1 cycle.
- Config variant: SYNC_STAGES=0, IN_REG=0, OUT_REG=0 -> in_data follows in_pin same cycle; out_pin follows out_data combinationally; edge pulse appears 1 cycle after the pin change.
